// File: rtl/nco_bit_clock.sv
// Phase-accumulator NCO recovering a bit clock plus bit/word position counters.
// Latency: speed_var reaches the accumulator after 2 edges; all outputs registered; no backpressure.
module nco_bit_clock #(
    parameter int bit_count = 24,
    parameter int word_bits = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [bit_count-1:0] speed_var,
    input  logic                 en,
    input  logic                 phase_clr,
    output logic [bit_count-1:0] phase_acc,
    output logic                 nco_clk,
    output logic                 bit_tick,
    output logic [3:0]           bit_idx,
    output logic                 word_strobe
);

    localparam logic [3:0] last_idx = 4'(word_bits - 1);

    logic [bit_count-1:0] speed_reg;
    logic [bit_count:0]   sum;
    logic                 carry;

    assign sum     = {1'b0, phase_acc} + {1'b0, speed_reg};
    assign carry   = sum[bit_count];
    assign nco_clk = phase_acc[bit_count-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            speed_reg <= '0;
        end else begin
            speed_reg <= speed_var;
        end
    end

    // Realignment beats enable; a disabled or carry-free cycle never emits pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_acc   <= '0;
            bit_tick    <= 1'b0;
            bit_idx     <= '0;
            word_strobe <= 1'b0;
        end else if (phase_clr) begin
            phase_acc   <= '0;
            bit_tick    <= 1'b0;
            bit_idx     <= '0;
            word_strobe <= 1'b0;
        end else if (en) begin
            phase_acc   <= sum[bit_count-1:0];
            bit_tick    <= carry;
            word_strobe <= 1'b0;
            if (carry) begin
                if (bit_idx == last_idx) begin
                    bit_idx     <= '0;
                    word_strobe <= 1'b1;
                end else begin
                    bit_idx <= bit_idx + 4'd1;
                end
            end
        end else begin
            bit_tick    <= 1'b0;
            word_strobe <= 1'b0;
        end
    end

endmodule
